// File: rtl/pipeline_arb_pkg.sv
// Shared helpers for the round-robin pipeline arbiter.
package pipeline_arb_pkg;

  // Index width for n requesters; a single requester still gets one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Pointer advance with wrap at n (n need not be a power of two).
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping.
module rr_pick
  import pipeline_arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_valid
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic           found;

  assign dbl       = {req, req};
  assign any_valid = |req;

  // Drop bits below ptr; the upper copy supplies the wrapped-around requesters.
  always_comb begin
    masked = '0;
    for (int j = 0; j < int'(2 * N); j++) begin
      masked[j] = dbl[j] && (j >= int'(ptr));
    end
  end

  // Lowest surviving bit wins; fold the upper-copy index back into range.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int j = 0; j < int'(2 * N); j++) begin
      if (masked[j] && !found) begin
        winner = (j >= int'(N)) ? IDX_W'(j - int'(N)) : IDX_W'(j);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_rr_arb.sv
// Round-robin arbiter feeding one registered valid/ready slot shared by NUM_REQ requesters.
// Optional: define PIPELINE_ARB_SRC_ID_EN to add src_id_o, the winner index registered with data_out.
module pipeline_rr_arb
  import pipeline_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk_i,
  input  logic                       arst_n,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_out_valid,
`ifdef PIPELINE_ARB_SRC_ID_EN
  output logic [idx_width(NUM_REQ)-1:0] src_id_o,
`endif
  input  logic                       data_out_ready
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic             any_valid;
  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] win_data;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req       (req_valid_i),
    .ptr       (ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // Slot accepts when empty or draining; nothing is accepted while reset is asserted.
  assign can_load = !data_out_valid || data_out_ready;
  assign load     = arst_n && can_load && any_valid;

  // One-hot ready to the current winner only.
  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_ready_o[i] = load && (winner == IDX_W'(i)) && req_valid_i[i];
    end
  end

  // Winner word select.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (winner == IDX_W'(i)) win_data = req_data_i[i*WIDTH +: WIDTH];
    end
  end

  // Output slot and rotation pointer; a load during drain keeps the slot full.
  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      ptr            <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else if (load) begin
      ptr            <= IDX_W'(wrap_inc(32'(winner), NUM_REQ));
      data_out       <= win_data;
      data_out_valid <= 1'b1;
    end else if (data_out_ready) begin
      data_out_valid <= 1'b0;
    end
  end

`ifdef PIPELINE_ARB_SRC_ID_EN
  // Source index travels with the word it tags.
  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) src_id_o <= '0;
    else if (load) src_id_o <= winner;
  end
`endif

endmodule

// File: tb/tb_pipeline_rr_arb.sv
// Self-checking bench for pipeline_rr_arb: a 4-requester and a 3-requester instance,
// each compared cycle by cycle against a modular-arithmetic reference model.
module tb_pipeline_rr_arb;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  // NUM_REQ=4 instance
  logic [31:0] d4_data = '0;
  logic [3:0]  d4_valid = '0;
  logic [3:0]  d4_ready;
  logic [7:0]  d4_out;
  logic        d4_ov;
  logic        d4_oready = 1'b0;
  // NUM_REQ=3 instance
  logic [23:0] d3_data = '0;
  logic [2:0]  d3_valid = '0;
  logic [2:0]  d3_ready;
  logic [7:0]  d3_out;
  logic        d3_ov;
  logic        d3_oready = 1'b0;
`ifdef PIPELINE_ARB_SRC_ID_EN
  logic [1:0]  d4_src;
  logic [1:0]  d3_src;
`endif

  pipeline_rr_arb #(.WIDTH(8), .NUM_REQ(4)) dut4 (
    .clk_i          (clk),
    .arst_n         (arst_n),
    .req_data_i     (d4_data),
    .req_valid_i    (d4_valid),
    .req_ready_o    (d4_ready),
    .data_out       (d4_out),
    .data_out_valid (d4_ov),
`ifdef PIPELINE_ARB_SRC_ID_EN
    .src_id_o       (d4_src),
`endif
    .data_out_ready (d4_oready)
  );

  pipeline_rr_arb #(.WIDTH(8), .NUM_REQ(3)) dut3 (
    .clk_i          (clk),
    .arst_n         (arst_n),
    .req_data_i     (d3_data),
    .req_valid_i    (d3_valid),
    .req_ready_o    (d3_ready),
    .data_out       (d3_out),
    .data_out_valid (d3_ov),
`ifdef PIPELINE_ARB_SRC_ID_EN
    .src_id_o       (d3_src),
`endif
    .data_out_ready (d3_oready)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int         m4_ptr, m4_src, m3_ptr, m3_src;
  logic       m4_full, m3_full;
  logic [7:0] m4_data, m3_data;
  logic [5:0] in_seq [3];
  logic [5:0] out_seq [3];

  // First valid index scanning p, p+1, ... modulo n; -1 if none.
  function automatic int pick(input logic [7:0] v, input int n, input int p);
    int r = -1;
    for (int o = n - 1; o >= 0; o--) if (v[(p + o) % n]) r = (p + o) % n;
    return r;
  endfunction

  task automatic model_reset();
    m4_ptr = 0; m4_src = 0; m4_full = 1'b0; m4_data = '0;
    m3_ptr = 0; m3_src = 0; m3_full = 1'b0; m3_data = '0;
  endtask

  // Pulse reset with idle inputs; returns just after a posedge.
  task automatic do_reset();
    arst_n = 1'b0; d4_valid = '0; d3_valid = '0; d4_oready = 1'b0; d3_oready = 1'b0;
    @(posedge clk); #1;
    arst_n = 1'b1;
    model_reset();
  endtask

  // One clock for dut4: check ready mid-cycle, advance model, check outputs after the edge.
  task automatic cycle4(input string tag, output int g);
    int w; logic [3:0] er; logic can;
    @(negedge clk);
    w = pick({4'b0, d4_valid}, 4, m4_ptr);
    can = !m4_full || d4_oready;
    er = '0; g = -1;
    if (can && w >= 0) begin er[w] = 1'b1; g = w; end
    n_cmp++;
    if (d4_ready !== er) begin n_err++; $display("FAIL %s ready4: got %b want %b", tag, d4_ready, er); end
    if (g >= 0) begin
      m4_data = d4_data[g*8 +: 8]; m4_full = 1'b1; m4_src = g; m4_ptr = (g + 1) % 4;
    end else if (d4_oready) m4_full = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (d4_ov !== m4_full) begin n_err++; $display("FAIL %s valid4: got %b want %b", tag, d4_ov, m4_full); end
    n_cmp++;
    if (d4_out !== m4_data) begin n_err++; $display("FAIL %s data4: got %h want %h", tag, d4_out, m4_data); end
`ifdef PIPELINE_ARB_SRC_ID_EN
    n_cmp++;
    if (d4_src !== 2'(m4_src)) begin n_err++; $display("FAIL %s src4: got %0d want %0d", tag, d4_src, m4_src); end
`endif
  endtask

  // One clock for dut3, with a per-requester ordering scoreboard on drained words.
  task automatic cycle3(input string tag, output int g);
    int w, s; logic [2:0] er; logic can;
    @(negedge clk);
    if (d3_ov && d3_oready) begin
      s = int'(d3_out[7:6]);
      n_cmp++;
      if (s > 2) begin
        n_err++; $display("FAIL %s sb_src: got %0d want <3", tag, s);
      end else begin
        if (d3_out[5:0] !== out_seq[s]) begin
          n_err++; $display("FAIL %s sb_seq req%0d: got %0d want %0d", tag, s, d3_out[5:0], out_seq[s]);
        end
        out_seq[s] = out_seq[s] + 6'd1;
      end
    end
    w = pick({5'b0, d3_valid}, 3, m3_ptr);
    can = !m3_full || d3_oready;
    er = '0; g = -1;
    if (can && w >= 0) begin er[w] = 1'b1; g = w; end
    n_cmp++;
    if (d3_ready !== er) begin n_err++; $display("FAIL %s ready3: got %b want %b", tag, d3_ready, er); end
    if (g >= 0) begin
      m3_data = d3_data[g*8 +: 8]; m3_full = 1'b1; m3_src = g; m3_ptr = (g + 1) % 3;
    end else if (d3_oready) m3_full = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (d3_ov !== m3_full) begin n_err++; $display("FAIL %s valid3: got %b want %b", tag, d3_ov, m3_full); end
    n_cmp++;
    if (d3_out !== m3_data) begin n_err++; $display("FAIL %s data3: got %h want %h", tag, d3_out, m3_data); end
`ifdef PIPELINE_ARB_SRC_ID_EN
    n_cmp++;
    if (d3_src !== 2'(m3_src)) begin n_err++; $display("FAIL %s src3: got %0d want %0d", tag, d3_src, m3_src); end
`endif
  endtask

  task automatic test_reset();
    int g; logic [7:0] w0;
    #2;
    n_cmp++;
    if (d4_ov !== 1'b0 || d4_out !== 8'h00 || d4_ready !== 4'b0) begin
      n_err++; $display("FAIL por: got v=%b d=%h r=%b want 0/00/0000", d4_ov, d4_out, d4_ready);
    end
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 4; i++) d4_data[i*8 +: 8] = 8'($urandom);
    d4_valid = 4'hF;
    cycle4("rst_fill", g);
    cycle4("rst_stall", g);
    // Assert reset mid-cycle with a full slot and a ready downstream.
    d4_oready = 1'b1;
    arst_n = 1'b0;
    #1;
    n_cmp++;
    if (d4_ov !== 1'b0 || d4_out !== 8'h00) begin
      n_err++; $display("FAIL rst_async: got v=%b d=%h want 0/00", d4_ov, d4_out);
    end
    n_cmp++;
    if (d4_ready !== 4'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0000", d4_ready); end
    @(posedge clk); #1;
    n_cmp++;
    if (d4_ov !== 1'b0 || d4_ready !== 4'b0) begin
      n_err++; $display("FAIL rst_hold: got v=%b r=%b want 0/0000", d4_ov, d4_ready);
    end
    arst_n = 1'b1;
    model_reset();
    w0 = d4_data[7:0];
    cycle4("rst_first", g);
    n_cmp++;
    if (d4_out !== w0) begin n_err++; $display("FAIL rst_first_grant: got %h want %h", d4_out, w0); end
  endtask

  task automatic test_rotate();
    int g; logic [7:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) d4_data[i*8 +: 8] = 8'hA0 + 8'(i);
    d4_valid = 4'hF; d4_oready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle4("rotate", g);
      e = 8'hA0 + 8'(k % 4);
      n_cmp++;
      if (d4_out !== e || d4_ov !== 1'b1) begin
        n_err++; $display("FAIL rotate[%0d]: got %h v=%b want %h v=1", k, d4_out, d4_ov, e);
      end
    end
  endtask

  task automatic test_single();
    int g; logic [7:0] e;
    do_reset();
    d4_valid = 4'b0100; d4_oready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d4_data[23:16] = 8'($urandom);
      e = d4_data[23:16];
      cycle4("single2", g);
      n_cmp++;
      if (d4_out !== e) begin n_err++; $display("FAIL single2[%0d]: got %h want %h", k, d4_out, e); end
    end
    for (int i = 0; i < 4; i++) d4_data[i*8 +: 8] = 8'($urandom);
    d4_valid = 4'b1001;
    e = d4_data[31:24];
    cycle4("pair03", g);
    n_cmp++;
    if (d4_out !== e) begin n_err++; $display("FAIL pair03_first: got %h want %h (req3)", d4_out, e); end
    e = d4_data[7:0];
    cycle4("pair03", g);
    n_cmp++;
    if (d4_out !== e) begin n_err++; $display("FAIL pair03_next: got %h want %h (req0)", d4_out, e); end
  endtask

  task automatic test_stall();
    int g; logic [7:0] e;
    do_reset();
    d4_data[7:0] = 8'h5A; d4_valid = 4'b0001; d4_oready = 1'b0;
    cycle4("stall_load", g);
    for (int i = 1; i < 4; i++) d4_data[i*8 +: 8] = 8'($urandom);
    d4_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      cycle4("stall", g);
      n_cmp++;
      if (d4_out !== 8'h5A || d4_ov !== 1'b1 || d4_ready !== 4'b0) begin
        n_err++; $display("FAIL stall[%0d]: got d=%h v=%b r=%b want 5a/1/0000", k, d4_out, d4_ov, d4_ready);
      end
    end
    d4_oready = 1'b1;
    e = d4_data[15:8];
    cycle4("stall_release", g);
    n_cmp++;
    if (d4_out !== e || d4_ov !== 1'b1) begin
      n_err++; $display("FAIL stall_release: got d=%h v=%b want %h/1", d4_out, d4_ov, e);
    end
  endtask

  task automatic test_wrap3();
    int g;
    do_reset();
    for (int i = 0; i < 3; i++) begin in_seq[i] = '0; out_seq[i] = '0; end
    for (int i = 0; i < 3; i++) d3_data[i*8 +: 8] = {2'(i), in_seq[i]};
    d3_valid = 3'b100; d3_oready = 1'b1;
    cycle3("wrap_r2", g);
    n_cmp++;
    if (d3_out !== 8'h80) begin n_err++; $display("FAIL wrap_r2: got %h want 80", d3_out); end
    if (g >= 0) in_seq[g] = in_seq[g] + 6'd1;
    for (int i = 0; i < 3; i++) d3_data[i*8 +: 8] = {2'(i), in_seq[i]};
    d3_valid = 3'b111;
    cycle3("wrap_r0", g);
    n_cmp++;
    if (d3_out !== 8'h00) begin n_err++; $display("FAIL wrap_r0: got %h want 00 (req0 after wrap)", d3_out); end
    if (g >= 0) in_seq[g] = in_seq[g] + 6'd1;
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!d3_valid[i]) d3_valid[i] = ($urandom_range(0, 2) != 0);
        else if ($urandom_range(0, 7) == 0) d3_valid[i] = 1'b0;
        d3_data[i*8 +: 8] = {2'(i), in_seq[i]};
      end
      d3_oready = 1'($urandom_range(0, 1));
      cycle3("wrap_rand", g);
      if (g >= 0) in_seq[g] = in_seq[g] + 6'd1;
    end
    d3_valid = '0; d3_oready = 1'b1;
    cycle3("wrap_drain", g);
    cycle3("wrap_drain", g);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_seq[i] !== in_seq[i]) begin
        n_err++; $display("FAIL wrap_count req%0d: got %0d want %0d", i, out_seq[i], in_seq[i]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotate();
    test_single();
    test_stall();
    test_wrap3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
